// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions for the ExternalMem arbiter: FSM state type,
// requester port ids and memory geometry.
package cpu_pkg;

    localparam int unsigned EXTMEM_ADDR_W = 8;
    localparam int unsigned EXTMEM_DATA_W = 16;

    localparam logic PORT_ALU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

endpackage

// File: rtl/extmem_arbiter_if.sv
// Requester, memory-pin and debug signals of the ExternalMem arbiter.
// slave = arbiter side, master = requesters plus the memory itself.
interface extmem_arbiter_if #(
    parameter int unsigned ADDR_W = cpu_pkg::EXTMEM_ADDR_W,
    parameter int unsigned DATA_W = cpu_pkg::EXTMEM_DATA_W
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              rvalid0;
    logic              rvalid1;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic [3:0]        starve_cnt;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
               mem_addr, mem_wdata, mem_we, busy, starve_cnt
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
               mem_addr, mem_wdata, mem_we, busy, starve_cnt
    );

endinterface

// File: rtl/extmem_arbiter.sv
// Two-requester arbiter for the single-port ExternalMem. Port 0 (ALU) has
// priority; a saturating starvation counter forces port 1 (debug) through
// after STARVE_MAX lost arbitrations. Each access is IDLE -> ACCESS -> IDLE.
module extmem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W     = EXTMEM_ADDR_W,
    parameter int unsigned DATA_W     = EXTMEM_DATA_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic             clk,
    input logic             rst,
    extmem_arbiter_if.slave bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t        state_q, state_d;
    logic              id_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        starve_q, starve_d;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              rvalid0_q, rvalid1_q;
    logic              load;
    logic              win_id;

    // Port 1 wins when alone, or when it has been starved long enough.
    function automatic logic pick_winner(input logic r0, input logic r1,
                                         input logic [3:0] cnt);
        return r1 && (!r0 || cnt == STARVE_LIM);
    endfunction

    // Next-state, arbitration and memory-pin drive.
    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        load          = 1'b0;
        win_id        = PORT_ALU;
        bus.gnt0      = 1'b0;
        bus.gnt1      = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    load    = 1'b1;
                    win_id  = pick_winner(bus.req0, bus.req1, starve_q);
                    state_d = ACCESS;
                    if (win_id == PORT_DBG) begin
                        starve_d = '0;
                    end else if (bus.req1 && starve_q != STARVE_LIM) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            ACCESS: begin
                state_d       = IDLE;
                bus.busy      = 1'b1;
                bus.gnt0      = (id_q == PORT_ALU);
                bus.gnt1      = (id_q == PORT_DBG);
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
                bus.mem_we    = we_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and starvation counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Latch the winner's transaction when leaving IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q    <= PORT_ALU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (load) begin
            id_q    <= win_id;
            we_q    <= (win_id == PORT_DBG) ? bus.we1    : bus.we0;
            addr_q  <= (win_id == PORT_DBG) ? bus.addr1  : bus.addr0;
            wdata_q <= (win_id == PORT_DBG) ? bus.wdata1 : bus.wdata0;
        end
    end

    // Capture read data at the end of ACCESS and pulse rvalid the cycle after.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= (state_q == ACCESS) && !we_q && (id_q == PORT_ALU);
            rvalid1_q <= (state_q == ACCESS) && !we_q && (id_q == PORT_DBG);
            if ((state_q == ACCESS) && !we_q) begin
                if (id_q == PORT_ALU) rdata0_q <= bus.mem_rdata;
                else                  rdata1_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.rdata0     = rdata0_q;
    assign bus.rdata1     = rdata1_q;
    assign bus.rvalid0    = rvalid0_q;
    assign bus.rvalid1    = rvalid1_q;
    assign bus.starve_cnt = starve_q;

endmodule

// File: tb/tb_extmem_arbiter.sv
// Bench for extmem_arbiter: ExternalMem model, transaction-level reference
// model compared every cycle, and directed scenarios with literal checks.
module tb_extmem_arbiter;

    localparam int unsigned SMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    extmem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    extmem_arbiter #(.ADDR_W(8), .DATA_W(16), .STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] preload_val(input logic [7:0] a);
        case (a)
            8'd1:    return 16'h0012;
            8'd3:    return 16'h0004;
            default: return {8'hA5, a};
        endcase
    endfunction

    // ExternalMem: combinational read, write on rising edge.
    logic [15:0] ext_mem [256];
    bit          loaded = 1'b0;
    assign bus.mem_rdata = ext_mem[bus.mem_addr];
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) ext_mem[i] <= preload_val(8'(i));
            loaded <= 1'b1;
        end else if (bus.mem_we) begin
            ext_mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one pending transaction, per-port read results,
    // counter of lost simultaneous arbitrations, record of written words.
    bit          m_busy = 1'b0;
    logic        m_port = 1'b0;
    logic        m_we = 1'b0;
    logic [7:0]  m_addr = '0;
    logic [15:0] m_wdata = '0;
    logic [1:0]  m_rv = '0;
    logic [15:0] m_rdata [2];
    int          m_starve = 0;
    logic [15:0] m_wr [256];
    bit          m_wr_v [256];

    function automatic logic [15:0] exp_mem(input logic [7:0] a);
        return m_wr_v[a] ? m_wr[a] : preload_val(a);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy     <= 1'b0;
            m_rv       <= '0;
            m_rdata[0] <= '0;
            m_rdata[1] <= '0;
            m_starve   <= 0;
        end else begin
            m_rv <= '0;
            if (m_busy) begin
                m_busy <= 1'b0;
                if (m_we) begin
                    m_wr[m_addr]   <= m_wdata;
                    m_wr_v[m_addr] <= 1'b1;
                end else begin
                    m_rv[m_port]    <= 1'b1;
                    m_rdata[m_port] <= exp_mem(m_addr);
                end
            end else if (bus.req0 || bus.req1) begin
                automatic bit p1 = bus.req1 && (!bus.req0 || m_starve == int'(SMAX));
                m_busy  <= 1'b1;
                m_port  <= p1;
                m_we    <= p1 ? bus.we1 : bus.we0;
                m_addr  <= p1 ? bus.addr1 : bus.addr0;
                m_wdata <= p1 ? bus.wdata1 : bus.wdata0;
                if (p1) m_starve <= 0;
                else if (bus.req1) m_starve <= (m_starve + 1 > int'(SMAX)) ? int'(SMAX) : m_starve + 1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("busy",      32'(bus.busy),      32'(m_busy));
        chk("gnt0",      32'(bus.gnt0),      32'(m_busy && m_port == 1'b0));
        chk("gnt1",      32'(bus.gnt1),      32'(m_busy && m_port == 1'b1));
        chk("mem_we",    32'(bus.mem_we),    32'(m_busy && m_we));
        chk("mem_addr",  32'(bus.mem_addr),  m_busy ? 32'(m_addr)  : 32'd0);
        chk("mem_wdata", 32'(bus.mem_wdata), m_busy ? 32'(m_wdata) : 32'd0);
        chk("rvalid0",   32'(bus.rvalid0),   32'(m_rv[0]));
        chk("rvalid1",   32'(bus.rvalid1),   32'(m_rv[1]));
        chk("rdata0",    32'(bus.rdata0),    32'(m_rdata[0]));
        chk("rdata1",    32'(bus.rdata1),    32'(m_rdata[1]));
        chk("starve",    32'(bus.starve_cnt), 32'(m_starve));
    end

    // One access: raise req, drop it in the grant cycle, wait for rvalid on reads.
    task automatic do_access(input bit port, input logic we, input logic [7:0] addr,
                             input logic [15:0] wd, output logic g_we,
                             output logic [7:0] g_addr, output logic [15:0] g_wdata,
                             output logic [15:0] rd);
        bit got = 1'b0;
        g_we = 1'b0; g_addr = '0; g_wdata = '0; rd = '0;
        if (port) begin bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd; end
        else      begin bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd; end
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (port ? bus.gnt1 : bus.gnt0) begin
                got = 1'b1;
                g_we = bus.mem_we; g_addr = bus.mem_addr; g_wdata = bus.mem_wdata;
                if (port) bus.req1 = 1'b0; else bus.req0 = 1'b0;
            end
        end
        chk("grant_seen", 32'(got), 32'd1);
        if (!got) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
        if (got && !we) begin
            @(negedge clk);
            chk("rvalid_pulse", 32'(port ? bus.rvalid1 : bus.rvalid0), 32'd1);
            rd = port ? bus.rdata1 : bus.rdata0;
        end
    endtask

    initial begin
        logic        g_we;
        logic [7:0]  g_addr;
        logic [15:0] g_wdata, rd;
        int          n;
        int          ids [6];
        int          scs [6];
        int          exp_ids [6];
        int          exp_scs [6];

        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_busy",   32'(bus.busy), 32'd0);
        chk("rst_starve", 32'(bus.starve_cnt), 32'd0);
        chk("rst_rdata0", 32'(bus.rdata0), 32'd0);

        // Single read of preloaded mem[1]
        do_access(1'b0, 1'b0, 8'd1, 16'h0, g_we, g_addr, g_wdata, rd);
        chk("read_we_low", 32'(g_we), 32'd0);
        chk("read_addr",   32'(g_addr), 32'd1);
        chk("read_data",   32'(rd), 32'h0012);

        // Single write from port 1, then port-0 read back
        do_access(1'b1, 1'b1, 8'd5, 16'hBEEF, g_we, g_addr, g_wdata, rd);
        chk("write_we",    32'(g_we), 32'd1);
        chk("write_addr",  32'(g_addr), 32'd5);
        chk("write_wdata", 32'(g_wdata), 32'hBEEF);
        do_access(1'b0, 1'b0, 8'd5, 16'h0, g_we, g_addr, g_wdata, rd);
        chk("raw_data",    32'(rd), 32'hBEEF);

        // Priority: simultaneous requests with counter at 0
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'd1;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'd5;
        @(negedge clk);
        chk("prio_gnt0",   32'(bus.gnt0), 32'd1);
        chk("prio_gnt1",   32'(bus.gnt1), 32'd0);
        chk("prio_starve", 32'(bus.starve_cnt), 32'd1);
        bus.req0 = 0;
        @(negedge clk);
        chk("prio_gap",    32'(bus.gnt1), 32'd0);
        @(negedge clk);
        chk("prio_gnt1b",  32'(bus.gnt1), 32'd1);
        chk("prio_clear",  32'(bus.starve_cnt), 32'd0);
        bus.req1 = 0;
        @(negedge clk);
        chk("prio_rv1",    32'(bus.rvalid1), 32'd1);
        chk("prio_rd1",    32'(bus.rdata1), 32'hBEEF);

        // Starvation: both requests held continuously
        exp_ids = '{0, 0, 0, 0, 1, 0};
        exp_scs = '{1, 2, 3, 4, 0, 1};
        n = 0;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'd7;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'd9;
        for (int i = 0; i < 30 && n < 6; i++) begin
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1) begin
                ids[n] = int'(bus.gnt1);
                scs[n] = int'(bus.starve_cnt);
                n++;
                if (n == 6) begin bus.req0 = 0; bus.req1 = 0; end
            end
        end
        bus.req0 = 0; bus.req1 = 0;
        chk("starve_grants", 32'(n), 32'd6);
        for (int i = 0; i < n; i++) begin
            chk("starve_id",  32'(ids[i]), 32'(exp_ids[i]));
            chk("starve_cnt", 32'(scs[i]), 32'(exp_scs[i]));
        end
        repeat (2) @(negedge clk);

        // Reset during ACCESS of a write to address 3
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'd3; bus.wdata0 = 16'h1234;
        @(negedge clk);
        chk("rstmid_gnt0", 32'(bus.gnt0), 32'd1);
        chk("rstmid_we",   32'(bus.mem_we), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_we_drop", 32'(bus.mem_we), 32'd0);
        chk("rstmid_gnt_drop", 32'(bus.gnt0), 32'd0);
        chk("rstmid_busy",  32'(bus.busy), 32'd0);
        chk("rstmid_rdata0", 32'(bus.rdata0), 32'd0);
        chk("rstmid_rdata1", 32'(bus.rdata1), 32'd0);
        bus.req0 = 0; bus.we0 = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_mem3",  32'(ext_mem[3]), 32'h0004);
        chk("rstmid_rv0",   32'(bus.rvalid0), 32'd0);

        // Idle for 20 cycles
        repeat (20) begin
            @(negedge clk);
            chk("idle_quiet", 32'({bus.busy, bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_we}), 32'd0);
        end
        chk("idle_starve", 32'(bus.starve_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/extmem_arbiter.md
# extmem_arbiter

Two-requester arbiter for the single-port ExternalMem (8-bit address, 16-bit data). It shares the memory between the ALU micro-op memory path (port 0, priority) and a debug/loader port (port 1). Each access is a registered two-state transaction, and the block drives the memory's address, write-data and write-enable pins. A starvation counter guarantees that port 1 makes progress under continuous port-0 traffic.

## Interface
Parameters:
- `ADDR_W`, 8: memory address width.
- `DATA_W`, 16: memory data width.
- `STARVE_MAX`, 4: number of lost arbitrations after which port 1 is forced to win. Legal range 1..15.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req0` / `req1` in 1: access request. Held high with a stable payload until the matching `gnt` pulse.
- `we0` / `we1` in 1: 1 = write, 0 = read.
- `addr0` / `addr1` in ADDR_W: access address.
- `wdata0` / `wdata1` in DATA_W: write data.
- `gnt0` / `gnt1` out 1: one-cycle pulse, high during the memory access cycle.
- `rdata0` / `rdata1` out DATA_W: registered read data.
- `rvalid0` / `rvalid1` out 1: one-cycle pulse, read data valid.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_we` out 1: memory write enable. ExternalMem writes on the rising edge.
- `mem_rdata` in DATA_W: memory read data, combinational from `mem_addr`.
- `busy` out 1: high in ACCESS.
- `starve_cnt` out 4: current starvation count, for debug.

## Operation
The FSM has two states, IDLE and ACCESS.

IDLE:
- If no request is present, stay in IDLE.
- If either request is high, select a winner and latch the winner's id, `we`, `addr` and `wdata` into registers. Go to ACCESS.
- Winner rule: port 1 wins if `req1 && (!req0 || starve_cnt == STARVE_MAX)`. Otherwise port 0 wins.

ACCESS:
- Assert `gnt<id>`.
- Drive the `mem_*` outputs from the latched registers. `mem_we` equals the latched `we`.
- For a read, sample `mem_rdata` into `rdata<id>` at the end of the cycle and pulse `rvalid<id>` in the following cycle.
- Always return to IDLE.

Starvation counter:
- Increments, saturating at STARVE_MAX, on each IDLE decision where `req1 && req0` and port 0 wins.
- Clears to 0 when port 1 wins.
- Is otherwise unchanged.

Output defaults:
- Outside ACCESS: `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, both `gnt` = 0.
- `rdata0` and `rdata1` hold their last value until the next read on that port.

## Timing
Access cycle:
- Cycle t: request sampled in IDLE.
- Cycle t+1: ACCESS, `gnt` high, memory driven. A write lands at the end of t+1.
- Cycle t+2: `rvalid` and `rdata` for a read. The FSM is back in IDLE and can arbitrate a new request.

Throughput and handshake:
- Peak throughput is one access per 2 cycles.
- Back-to-back accesses from the same port need `req` held (or re-asserted) in t+2. A request still high in t+2 is a new request.
- A requester must drop `req` in the cycle after `gnt` if it wants only one access.

Reset values:
- FSM = IDLE, `starve_cnt` = 0.
- All `gnt`, `rvalid`, `busy` and `mem_we` = 0.
- `rdata0` / `rdata1` = 0.

Boundary conditions:
- Reset mid-ACCESS: `mem_we` drops immediately (asynchronous), the access is aborted, and no `rvalid` is produced.
- Simultaneous requests with `starve_cnt < STARVE_MAX`: port 0 wins.
- Simultaneous requests with `starve_cnt == STARVE_MAX`: port 1 wins and the counter clears.
- `req` deasserted before `gnt`: the request is ignored. This is illegal per protocol but harmless.
- A request arriving during ACCESS is not considered until the next IDLE cycle.
- Both ports addressing the same location: accesses are serialized in grant order. A read after a write returns the new data.

## Structure
- Shared package `cpu_pkg` holds:
  - the FSM state enum `arb_state_t` (IDLE, ACCESS);
  - the port id localparams `PORT_ALU` = 0 and `PORT_DBG` = 1;
  - `EXTMEM_ADDR_W` and `EXTMEM_DATA_W`.
- Single module with no sub-modules. Winner selection is an inline combinational function.

## Test plan
- Single read: memory preloaded with mem[1] = 16'h0012. `req0=1`, `we0=0`, `addr0=1` → `gnt0` at t+1, `rvalid0` at t+2 with `rdata0 = 16'h0012`, `mem_we` never high.
- Single write: `req1=1`, `we1=1`, `addr1=5`, `wdata1=16'hBEEF` → `gnt1` at t+1 with `mem_we=1`. A following port-0 read of address 5 returns 16'hBEEF.
- Priority: `req0` and `req1` asserted in the same cycle, counter at 0 → `gnt0` first, then `gnt1` two cycles later after `req0` drops.
- Starvation: `req0` held continuously, `req1` held, `STARVE_MAX=4` → 4 port-0 grants (`starve_cnt` reaching 4), then `gnt1`, then `starve_cnt=0` and port 0 resumes.
- Reset mid-operation: assert `rst=0` during ACCESS of a write to address 3 (mem[3] preloaded 16'h0004) → `mem_we` falls immediately, mem[3] stays 16'h0004, all outputs return to reset values.
- Idle: no requests for 20 cycles → `busy`, `gnt*`, `rvalid*` and `mem_we` all stay 0 and `starve_cnt` stays 0.
